branch_resolver: RTL and testbench

- Consumer of the ALU flag outputs (zero, negative, overflow, carry) for compare operations.
- Evaluates RV32I branch and jump conditions, computes the redirect target, and hands the decision to the fetch/hazard logic.
- Input side is a valid/ready handshake from the execute stage; output side is a 2-entry FIFO with valid/ready.
- Also keeps saturating counters of resolved branches and taken branches for performance visibility.

---
 rtl/branch_resolver.sv | 132 +++++++++++++
 tb/tb_branch_resolver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// RV32I branch/jump resolver: evaluates the condition from ALU compare flags, computes the
// redirect target, and queues the decision in a 2-entry valid/ready FIFO with saturating statistics.
module branch_resolver #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_CNT_WIDTH  = 16
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [1:0]               ikind,
    input  logic [2:0]               ifunct3,
    input  logic                     izero,
    input  logic                     inegative,
    input  logic                     ioverflow,
    input  logic                     icarry,
    input  logic [MP_DATA_WIDTH-1:0] ipc,
    input  logic [MP_DATA_WIDTH-1:0] iimm,
    input  logic [MP_DATA_WIDTH-1:0] irs1,
    output logic                     ovalid,
    input  logic                     iready,
    output logic                     otaken,
    output logic [MP_DATA_WIDTH-1:0] otarget,
    output logic                     oillegal,
    output logic [MP_CNT_WIDTH-1:0]  obr_count,
    output logic [MP_CNT_WIDTH-1:0]  otaken_count
);

    typedef struct packed {
        logic                     taken;
        logic                     illegal;
        logic [MP_DATA_WIDTH-1:0] target;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

    occ_e   state_q, state_d;
    entry_t new_entry;
    entry_t mem [2];
    logic   rd_ptr, wr_ptr;
    logic   push, pop;
    logic   cond_met;

    logic [MP_DATA_WIDTH-1:0] seq_target, rel_target, jalr_sum;

    assign seq_target = ipc + MP_DATA_WIDTH'(4);
    assign rel_target = ipc + iimm;
    assign jalr_sum   = irs1 + iimm;

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cond_met          = 1'b0;
        new_entry.taken   = 1'b0;
        new_entry.illegal = 1'b0;
        new_entry.target  = seq_target;
        case (ifunct3)
            3'b000:  cond_met = izero;
            3'b001:  cond_met = ~izero;
            3'b100:  cond_met = inegative ^ ioverflow;
            3'b101:  cond_met = ~(inegative ^ ioverflow);
            3'b110:  cond_met = ~icarry;
            3'b111:  cond_met = icarry;
            default: cond_met = 1'b0;
        endcase
        case (ikind)
            2'd0: begin
                new_entry.illegal = (ifunct3 == 3'b010) || (ifunct3 == 3'b011);
                new_entry.taken   = cond_met && !new_entry.illegal;
                if (new_entry.taken) new_entry.target = rel_target;
            end
            2'd1: begin
                new_entry.taken  = 1'b1;
                new_entry.target = rel_target;
            end
            2'd2: begin
                new_entry.taken  = 1'b1;
                new_entry.target = {jalr_sum[MP_DATA_WIDTH-1:1], 1'b0};
            end
            default: new_entry.illegal = 1'b1;
        endcase
    end

    assign oready = (state_q != FULL);
    assign ovalid = (state_q != EMPTY);
    assign push   = ivalid && oready;
    assign pop    = ovalid && iready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = FULL;
                     else if (pop && !push) state_d = EMPTY;
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: state and pointers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= EMPTY;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_ptr  <= rd_ptr ^ pop;
            wr_ptr  <= wr_ptr ^ push;
        end
    end

    // NOTE: entry storage is not reset; outputs are gated by ovalid, so stale contents never escape.
    always_ff @(posedge iclk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    assign otaken   = ovalid && mem[rd_ptr].taken;
    assign oillegal = ovalid && mem[rd_ptr].illegal;
    assign otarget  = ovalid ? mem[rd_ptr].target : '0;

    // Statistics count on acceptance and stick at all-ones.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            obr_count    <= '0;
            otaken_count <= '0;
        end else if (push) begin
            if (ikind == 2'd0 && obr_count != '1)     obr_count    <= obr_count + 1'b1;
            if (new_entry.taken && otaken_count != '1) otaken_count <= otaken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: random compares against an arithmetic reference model,
// directed boundary cases, FIFO backpressure, counter saturation and asynchronous reset.
module tb_branch_resolver;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int BUDGET = 200;

    typedef struct {
        logic          taken;
        logic          illegal;
        logic [DW-1:0] target;
    } exp_t;

    logic          iclk, irst_n, ivalid, oready, izero, inegative, ioverflow, icarry;
    logic [1:0]    ikind;
    logic [2:0]    ifunct3;
    logic [DW-1:0] ipc, iimm, irs1, otarget;
    logic          ovalid, iready, otaken, oillegal;
    logic [CW-1:0] obr_count, otaken_count;

    branch_resolver #(.MP_DATA_WIDTH(DW), .MP_CNT_WIDTH(CW)) dut (
        .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .oready(oready),
        .ikind(ikind), .ifunct3(ifunct3), .izero(izero), .inegative(inegative),
        .ioverflow(ioverflow), .icarry(icarry), .ipc(ipc), .iimm(iimm), .irs1(irs1),
        .ovalid(ovalid), .iready(iready), .otaken(otaken), .otarget(otarget),
        .oillegal(oillegal), .obr_count(obr_count), .otaken_count(otaken_count)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   mdl_br = 0;
    int   mdl_tk = 0;
    logic rand_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: the branch outcome comes straight from comparing the operands.
    function automatic exp_t model(input logic [1:0] kind, input logic [2:0] f3,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                                   input logic [DW-1:0] rs1);
        exp_t e;
        e.taken = 1'b0;
        e.illegal = 1'b0;
        if (kind == 2'd3 || (kind == 2'd0 && (f3 == 3'd2 || f3 == 3'd3))) e.illegal = 1'b1;
        else if (kind != 2'd0) e.taken = 1'b1;
        else begin
            case (f3)
                3'd0: e.taken = (a == b);
                3'd1: e.taken = (a != b);
                3'd4: e.taken = ($signed(a) < $signed(b));
                3'd5: e.taken = ($signed(a) >= $signed(b));
                3'd6: e.taken = (a < b);
                default: e.taken = (a >= b);
            endcase
        end
        if (!e.taken) e.target = pc + 32'd4;
        else if (kind == 2'd2) e.target = (rs1 + imm) & ~32'd1;
        else e.target = pc + imm;
        return e;
    endfunction

    task automatic send_req(input logic [1:0] kind, input logic [2:0] f3, input logic [3:0] flags,
                            input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                            input logic [DW-1:0] rs1, input exp_t e);
        int waited;
        @(negedge iclk);
        ikind = kind; ifunct3 = f3;
        {izero, inegative, ioverflow, icarry} = flags;
        ipc = pc; iimm = imm; irs1 = rs1;
        ivalid = 1'b1;
        waited = 0;
        while (!oready && waited < BUDGET) begin
            @(negedge iclk);
            waited++;
        end
        if (!oready) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no oready after %0d cycles, expected acceptance", waited);
            ivalid = 1'b0;
            return;
        end
        sb.push_back(e);
        if (kind == 2'd0 && mdl_br != 32'hFFFF) mdl_br++;
        if (e.taken && mdl_tk != 32'hFFFF) mdl_tk++;
        @(posedge iclk);
        #1;
        ivalid = 1'b0;
        check("obr_count", 64'(obr_count), 64'(mdl_br));
        check("otaken_count", 64'(otaken_count), 64'(mdl_tk));
    endtask

    task automatic send_cmp(input logic [1:0] kind, input logic [2:0] f3,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                            input logic [DW-1:0] rs1);
        logic [DW-1:0] d;
        logic [3:0]    flags;
        d = a - b;
        flags[3] = (d == '0);
        flags[2] = d[DW-1];
        flags[1] = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
        flags[0] = (a >= b);
        send_req(kind, f3, flags, pc, imm, rs1, model(kind, f3, a, b, pc, imm, rs1));
    endtask

    task automatic send_random(input logic [1:0] kind);
        logic [DW-1:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 3) == 0) b = {~a[DW-1], a[DW-2:0]};
        send_cmp(kind, 3'($urandom_range(0, 7)), a, b, $urandom, $urandom, $urandom);
    endtask

    function automatic exp_t mk(input logic t, input logic il, input logic [DW-1:0] tg);
        exp_t e;
        e.taken = t; e.illegal = il; e.target = tg;
        return e;
    endfunction

    // Monitor: compares the head against the scoreboard on every pop, and checks hold stability.
    logic          have_prev = 1'b0;
    logic          prev_taken, prev_illegal;
    logic [DW-1:0] prev_target;
    always @(negedge iclk) begin
        if (!irst_n) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && ovalid) begin
                check("hold_stable", {otaken, oillegal, otarget}, {prev_taken, prev_illegal, prev_target});
            end
            if (ovalid && iready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pop: got entry target %0h, expected none", otarget);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("otaken", 64'(otaken), 64'(e.taken));
                    check("oillegal", 64'(oillegal), 64'(e.illegal));
                    check("otarget", 64'(otarget), 64'(e.target));
                end
            end
            have_prev    = ovalid && !iready;
            prev_taken   = otaken;
            prev_illegal = oillegal;
            prev_target  = otarget;
        end
    end

    initial begin
        irst_n = 1'b0; ivalid = 1'b0; iready = 1'b1;
        ikind = '0; ifunct3 = '0; {izero, inegative, ioverflow, icarry} = '0;
        ipc = '0; iimm = '0; irs1 = '0;
        repeat (2) @(posedge iclk);
        #1;
        check("rst_ovalid", 64'(ovalid), 64'd0);
        check("rst_outputs", {otaken, oillegal, otarget}, 64'd0);
        check("rst_oready", 64'(oready), 64'd1);
        check("rst_counts", {obr_count, otaken_count}, 64'd0);
        @(negedge iclk);
        irst_n = 1'b1;

        // Directed cases from the plan.
        send_req(2'd0, 3'b000, 4'b1000, 32'h100, 32'h20, 32'h0, mk(1'b1, 1'b0, 32'h120));
        check("latency_ovalid", 64'(ovalid), 64'd1);
        send_req(2'd0, 3'b100, 4'b0110, 32'h200, 32'h40, 32'h0, mk(1'b0, 1'b0, 32'h204));
        send_req(2'd0, 3'b110, 4'b0000, 32'h300, 32'hFFFF_FFF0, 32'h0, mk(1'b1, 1'b0, 32'h2F0));
        send_req(2'd2, 3'b011, 4'b1111, 32'h400, 32'h4, 32'h1003, mk(1'b1, 1'b0, 32'h1006));
        send_req(2'd1, 3'b000, 4'b0000, 32'hFFFF_FFF0, 32'h20, 32'h0, mk(1'b1, 1'b0, 32'h10));
        send_req(2'd0, 3'b010, 4'b1001, 32'h500, 32'h8, 32'h0, mk(1'b0, 1'b1, 32'h504));
        send_req(2'd3, 3'b000, 4'b1111, 32'hFFFF_FFFC, 32'h8, 32'h0, mk(1'b0, 1'b1, 32'h0));

        // Backpressure: two fill the FIFO, the third waits for a single pop.
        @(posedge iclk); #1 iready = 1'b0;
        send_req(2'd1, 3'b000, 4'b0000, 32'h1000, 32'h10, 32'h0, mk(1'b1, 1'b0, 32'h1010));
        check("one_oready", 64'(oready), 64'd1);
        send_req(2'd1, 3'b000, 4'b0000, 32'h2000, 32'h20, 32'h0, mk(1'b1, 1'b0, 32'h2020));
        check("full_oready", 64'(oready), 64'd0);
        fork
            send_req(2'd1, 3'b000, 4'b0000, 32'h3000, 32'h30, 32'h0, mk(1'b1, 1'b0, 32'h3030));
            begin
                repeat (3) @(posedge iclk);
                #1 check("still_full", 64'(oready), 64'd0);
                iready = 1'b1;
                @(posedge iclk);
                #1 iready = 1'b0;
            end
        join
        repeat (2) @(posedge iclk);
        #1 check("refull_depth", {ovalid, oready}, 64'b10);
        iready = 1'b1;

        // Random traffic with random backpressure.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) send_random(2'($urandom_range(0, 3)));
                rand_on = 1'b0;
            end
            while (rand_on) begin
                @(posedge iclk);
                #1 iready = 1'($urandom_range(0, 1));
            end
        join
        @(posedge iclk); #1 iready = 1'b1;

        // Saturate the branch counter, then one more.
        while (mdl_br != 32'hFFFF) send_random(2'd0);
        send_random(2'd0);
        check("br_saturated", 64'(obr_count), 64'hFFFF);

        // Asynchronous reset with two entries queued.
        @(posedge iclk); #1 iready = 1'b0;
        send_random(2'd1);
        send_random(2'd0);
        #2 irst_n = 1'b0;
        #1;
        check("midrst_ovalid", 64'(ovalid), 64'd0);
        check("midrst_counts", {obr_count, otaken_count}, 64'd0);
        check("midrst_oready", 64'(oready), 64'd1);
        sb.delete();
        mdl_br = 0; mdl_tk = 0;
        @(negedge iclk);
        irst_n = 1'b1;
        iready = 1'b1;
        send_req(2'd0, 3'b001, 4'b0000, 32'h80, 32'h10, 32'h0, mk(1'b1, 1'b0, 32'h90));

        begin
            int waited;
            waited = 0;
            while (sb.size() != 0 && waited < BUDGET) begin
                @(posedge iclk);
                waited++;
            end
            if (sb.size() != 0) begin
                total++; bad++;
                $display("FAIL drain_timeout: got %0d entries outstanding, expected 0", sb.size());
            end
        end
        @(negedge iclk);
        check("end_empty", 64'(ovalid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
